alu_md: RTL and testbench
=========================

Name: alu_md

Overview:
- Parametrised successor to the core's combinational ALU. Adds the full MIPS-I integer operation set and an iterative multiply/divide unit with architectural HI/LO registers.
- Sits in EX. The combinational path produces AluResult_o/Zero_o in the same cycle.
- MULT/MULTU/DIV/DIVU run as a multi-cycle sequential job. Busy_o is used by hazard logic to stall MFHI/MFLO and further mul/div issue.

Parameters:
- WIDTH, 32: operand/result width (even, at least 8).
- CNT_W, $clog2(WIDTH): iteration counter width (derived, not overridden).

Ports:
- Clk_i  input  1  clock, rising edge.
- RstN_i  input  1  reset, synchronous, active-low.
- ScrA_i  input  WIDTH  operand A (rs); also the shift amount source for variable shifts.
- ScrB_i  input  WIDTH  operand B (rt/imm).
- AluControl_i  input  4  combinational operation select.
- MdOp_i  input  3  mul/div operation select.
- MdStart_i  input  1  issue strobe for MdOp_i.
- AluResult_o  output  WIDTH  combinational result.
- Zero_o  output  1  high when AluResult_o == 0.
- Busy_o  output  1  mul/div job in flight.
- Done_o  output  1  one-cycle completion pulse.
- Hi_o  output  WIDTH  HI register.
- Lo_o  output  WIDTH  LO register.

Behaviour:
- AluControl_i encodings (legacy codes unchanged):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed).
  - 0011 XOR, 0100 NOR, 1000 SLTU.
  - 1001 SLL, 1010 SRL, 1011 SRA: shift B by A[CNT_W-1:0].
  - 1100 LUI: B[WIDTH/2-1:0] placed in the upper half, lower half zero.
  - Others give 0.
- ADD/SUB wrap modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- MdOp_i encodings:
  - 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU.
  - 101 MTHI (HI<=ScrA_i), 110 MTLO (LO<=ScrA_i), 111 reserved (treated as NOP).
- FSM states: IDLE, RUN, FIX.
  - IDLE: MdStart_i with MULT..DIVU latches magnitudes and sign flags, clears the counter, then moves to RUN. Signed ops take magnitudes; unsigned ops take raw values.
  - IDLE: MTHI/MTLO write on that edge, single cycle, no state change, no Done_o.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle, WIDTH cycles, counter 0..WIDTH-1. On the last step go to FIX.
  - FIX: apply sign correction, write HI/LO, return to IDLE.
- Signed results:
  - Product is negated if operand signs differ.
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - MULT/MULTU: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Timing:
  - Busy_o = (state != IDLE) and rises the cycle after acceptance.
  - Done_o is high in the cycle after FIX, i.e. WIDTH+2 edges after the accepting edge; Busy_o is low in that cycle.
  - Hi_o/Lo_o are registered, change only at the FIX-exit edge or on MTHI/MTLO, and are stable while Busy_o is high.
- MdStart_i while Busy_o is high is ignored, including MTHI/MTLO; no queueing.
- Divide by zero: takes normal latency and does not trap.
  - LO = all ones.
  - HI = dividend (signed: original dividend).
- Signed overflow case (most-negative / -1): LO = most-negative, HI = 0.
- The combinational ALU path stays usable while Busy_o is high.
- Reset (RstN_i low at an edge), including mid-job:
  - state IDLE, counter 0.
  - HI = LO = 0.
  - Busy_o = 0, Done_o = 0.
  - The aborted job never produces Done_o.

Optional Feature:
- Macro: ALU_MD_OVF_EN.
- Defined: adds output Overflow_o (1 bit, combinational). It is high on signed overflow of ADD (0010) or SUB (0110) and low for all other codes. AluResult_o still carries the wrapped value.
- Undefined: port absent and no overflow logic.

Decomposition:
- Package alu_md_pkg holds the AluControl_i and MdOp_i encodings as localparams, plus the FSM state typedef enum {IDLE, RUN, FIX}.
- One sub-module, alu_md_iter, holds the RUN-state datapath: accumulator/remainder register, shift register, counter, and step logic.
- The top holds the combinational ALU, the FSM, sign handling and HI/LO.

Test Plan (WIDTH=32):
- AluControl_i=0111, A=FFFFFFFF, B=00000001 -> AluResult_o=1. Same operands with 1000 -> 0. 0110 with A=B=5 -> Zero_o=1.
- MULT A=FFFFFFFD (-3), B=00000005 -> Done_o pulses 34 edges after start; HI=FFFFFFFF, LO=FFFFFFF1; Busy_o high for exactly 33 cycles.
- DIV A=FFFFFFF9 (-7), B=00000002 -> LO=FFFFFFFD (-3), HI=FFFFFFFF (-1). DIVU A=7, B=0 -> LO=FFFFFFFF, HI=00000007.
- MULTU A=FFFFFFFF, B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001. A second MdStart_i mid-job (DIV) is ignored: HI/LO reflect the MULTU only, one Done_o.
- MTHI A=12345678 -> Hi_o=12345678 next cycle, no Done_o. Then MULT started and RstN_i low at RUN cycle 10 -> HI=LO=0, Busy_o=0, no Done_o afterwards.
- With ALU_MD_OVF_EN: ADD 7FFFFFFF+1 -> AluResult_o=80000000, Overflow_o=1. SUB 80000000-1 -> Overflow_o=1. ADD 1+1 -> 0.

Source files
------------

// File: rtl/alu_md_pkg.sv
// Shared encodings for alu_md: ALU operation codes, mul/div operation codes
// and the mul/div sequencer state type.
package alu_md_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_LUI  = 4'b1100;

    localparam logic [2:0] MD_NOP   = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MTHI  = 3'b101;
    localparam logic [2:0] MD_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // True for the operations that start a multi-cycle job.
    function automatic logic is_md_job(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative mul/div datapath: one shift-add (mul) or restoring-subtract (div)
// step per cycle on magnitude operands; acc ends as HI/remainder, sreg as LO/quotient.
module alu_md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sreg,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_r, sreg_r, opnd_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   sum_s, shifted_s, diff_s;
    logic [WIDTH-1:0] acc_nxt_s, sreg_nxt_s;

    // Next-step values; the div trial keeps one extra bit so a borrow is visible.
    always_comb begin
        sum_s      = {1'b0, acc_r} + (sreg_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        shifted_s  = {acc_r, sreg_r[WIDTH-1]};
        diff_s     = shifted_s - {1'b0, opnd_r};
        acc_nxt_s  = acc_r;
        sreg_nxt_s = sreg_r;
        if (is_div) begin
            if (!diff_s[WIDTH]) begin
                acc_nxt_s  = diff_s[WIDTH-1:0];
                sreg_nxt_s = {sreg_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s  = shifted_s[WIDTH-1:0];
                sreg_nxt_s = {sreg_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s  = sum_s[WIDTH:1];
            sreg_nxt_s = {sum_s[0], sreg_r[WIDTH-1:1]};
        end
    end

    // Datapath registers and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r  <= {WIDTH{1'b0}};
            sreg_r <= {WIDTH{1'b0}};
            opnd_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (load) begin
            acc_r  <= {WIDTH{1'b0}};
            sreg_r <= op_a;
            opnd_r <= op_b;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (step) begin
            acc_r  <= acc_nxt_s;
            sreg_r <= sreg_nxt_s;
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign acc  = acc_r;
    assign sreg = sreg_r;
    assign last = (cnt_r == LAST_CNT);

endmodule

// File: rtl/alu_md.sv
// MIPS-I EX-stage ALU with iterative mul/div unit and HI/LO registers.
// Optional macro ALU_MD_OVF_EN adds the combinational Overflow_o output for ADD/SUB.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk_i,
    input  logic             RstN_i,
    input  logic [WIDTH-1:0] ScrA_i,
    input  logic [WIDTH-1:0] ScrB_i,
    input  logic [3:0]       AluControl_i,
    input  logic [2:0]       MdOp_i,
    input  logic             MdStart_i,
    output logic [WIDTH-1:0] AluResult_o,
    output logic             Zero_o,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Hi_o,
    output logic [WIDTH-1:0] Lo_o
`ifdef ALU_MD_OVF_EN
    ,
    output logic             Overflow_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e        state_r, state_nxt_s;
    logic [WIDTH-1:0] alu_res_s, hi_r, lo_r, hi_res_s, lo_res_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s, iter_acc_s, iter_sreg_s, quo_fix_s, rem_fix_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [CNT_W-1:0] shamt_s;
    logic accept_s, step_s, fix_s, mthi_s, mtlo_s, iter_last_s;
    logic signed_op_s, a_neg_s, b_neg_s;
    logic is_div_r, neg_q_r, neg_r_r, div0_r, done_r;

    assign shamt_s = ScrA_i[CNT_W-1:0];

    // Single-cycle ALU.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (AluControl_i)
            ALU_AND:  alu_res_s = ScrA_i & ScrB_i;
            ALU_OR:   alu_res_s = ScrA_i | ScrB_i;
            ALU_ADD:  alu_res_s = ScrA_i + ScrB_i;
            ALU_XOR:  alu_res_s = ScrA_i ^ ScrB_i;
            ALU_NOR:  alu_res_s = ~(ScrA_i | ScrB_i);
            ALU_SUB:  alu_res_s = ScrA_i - ScrB_i;
            ALU_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(ScrA_i) < $signed(ScrB_i))};
            ALU_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (ScrA_i < ScrB_i)};
            ALU_SLL:  alu_res_s = ScrB_i << shamt_s;
            ALU_SRL:  alu_res_s = ScrB_i >> shamt_s;
            ALU_SRA:  alu_res_s = $signed(ScrB_i) >>> shamt_s;
            ALU_LUI:  alu_res_s = {ScrB_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default:  alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign AluResult_o = alu_res_s;
    assign Zero_o      = (alu_res_s == {WIDTH{1'b0}});

`ifdef ALU_MD_OVF_EN
    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result flips.
    always_comb begin
        Overflow_o = 1'b0;
        if (AluControl_i == ALU_ADD) begin
            Overflow_o = (ScrA_i[WIDTH-1] == ScrB_i[WIDTH-1]) && (alu_res_s[WIDTH-1] != ScrA_i[WIDTH-1]);
        end else if (AluControl_i == ALU_SUB) begin
            Overflow_o = (ScrA_i[WIDTH-1] != ScrB_i[WIDTH-1]) && (alu_res_s[WIDTH-1] != ScrA_i[WIDTH-1]);
        end else begin
            Overflow_o = 1'b0;
        end
    end
`endif

    // Sequencer state register.
    always_ff @(posedge Clk_i) begin
        if (!RstN_i) state_r <= IDLE;
        else         state_r <= state_nxt_s;
    end

    // Sequencer next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = (MdStart_i && is_md_job(MdOp_i)) ? RUN : IDLE;
            RUN:     state_nxt_s = iter_last_s ? FIX : RUN;
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sequencer control strobes; requests outside IDLE are dropped.
    always_comb begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        fix_s    = 1'b0;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = MdStart_i && is_md_job(MdOp_i);
                mthi_s   = MdStart_i && (MdOp_i == MD_MTHI);
                mtlo_s   = MdStart_i && (MdOp_i == MD_MTLO);
            end
            RUN:     step_s = 1'b1;
            FIX:     fix_s  = 1'b1;
            default: step_s = 1'b0;
        endcase
    end

    assign signed_op_s = (MdOp_i == MD_MULT) || (MdOp_i == MD_DIV);
    assign a_neg_s     = signed_op_s && ScrA_i[WIDTH-1];
    assign b_neg_s     = signed_op_s && ScrB_i[WIDTH-1];
    assign mag_a_s     = a_neg_s ? ({WIDTH{1'b0}} - ScrA_i) : ScrA_i;
    assign mag_b_s     = b_neg_s ? ({WIDTH{1'b0}} - ScrB_i) : ScrB_i;

    // Job attributes captured at acceptance for the final sign fix-up.
    always_ff @(posedge Clk_i) begin
        if (!RstN_i) begin
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
        end else if (accept_s) begin
            is_div_r <= (MdOp_i == MD_DIV) || (MdOp_i == MD_DIVU);
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            div0_r   <= ((MdOp_i == MD_DIV) || (MdOp_i == MD_DIVU)) && (ScrB_i == {WIDTH{1'b0}});
        end
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (Clk_i),
        .rst_n  (RstN_i),
        .load   (accept_s),
        .step   (step_s),
        .is_div (is_div_r),
        .op_a   (mag_a_s),
        .op_b   (mag_b_s),
        .acc    (iter_acc_s),
        .sreg   (iter_sreg_s),
        .last   (iter_last_s)
    );

    // Sign correction; negating |dividend| restores the original dividend for divide-by-zero.
    always_comb begin
        prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - {iter_acc_s, iter_sreg_s}) : {iter_acc_s, iter_sreg_s};
        quo_fix_s  = neg_q_r ? ({WIDTH{1'b0}} - iter_sreg_s) : iter_sreg_s;
        rem_fix_s  = neg_r_r ? ({WIDTH{1'b0}} - iter_acc_s) : iter_acc_s;
        if (is_div_r) begin
            hi_res_s = rem_fix_s;
            lo_res_s = div0_r ? {WIDTH{1'b1}} : quo_fix_s;
        end else begin
            hi_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Architectural HI/LO and completion pulse.
    always_ff @(posedge Clk_i) begin
        if (!RstN_i) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= fix_s;
            if (fix_s) begin
                hi_r <= hi_res_s;
                lo_r <= lo_res_s;
            end else begin
                if (mthi_s) hi_r <= ScrA_i;
                if (mtlo_s) lo_r <= ScrA_i;
            end
        end
    end

    assign Hi_o   = hi_r;
    assign Lo_o   = lo_r;
    assign Done_o = done_r;
    assign Busy_o = (state_r != IDLE);

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): random ALU and mul/div stimulus
// against an arithmetic reference model, plus the directed corner cases.
module tb_alu_md;
    import alu_md_pkg::*;

    logic        Clk_i = 1'b0;
    logic        RstN_i = 1'b0;
    logic [31:0] ScrA_i = 32'd0, ScrB_i = 32'd0;
    logic [3:0]  AluControl_i = 4'd0;
    logic [2:0]  MdOp_i = 3'd0;
    logic        MdStart_i = 1'b0;
    logic [31:0] AluResult_o, Hi_o, Lo_o;
    logic        Zero_o, Busy_o, Done_o;
`ifdef ALU_MD_OVF_EN
    logic        Overflow_o;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    alu_md #(.WIDTH(32)) dut (
        .Clk_i(Clk_i), .RstN_i(RstN_i), .ScrA_i(ScrA_i), .ScrB_i(ScrB_i),
        .AluControl_i(AluControl_i), .MdOp_i(MdOp_i), .MdStart_i(MdStart_i),
        .AluResult_o(AluResult_o), .Zero_o(Zero_o), .Busy_o(Busy_o), .Done_o(Done_o),
        .Hi_o(Hi_o), .Lo_o(Lo_o)
`ifdef ALU_MD_OVF_EN
        , .Overflow_o(Overflow_o)
`endif
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = 32'(a + b);
            4'b0011: r = a ^ b;
            4'b0100: r = ~(a | b);
            4'b0110: r = 32'(a - b);
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: r = (a < b) ? 32'd1 : 32'd0;
            4'b1001: r = 32'(longint'(b) * (longint'(1) << a[4:0]));
            4'b1010: r = 32'(longint'(b) / (longint'(1) << a[4:0]));
            4'b1011: r = 32'(sb >>> a[4:0]);
            4'b1100: r = b * 32'd65536;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'd0;
        lo = 32'd0;
        if (op == MD_MULT) begin
            p = 64'(sa * sb);
            hi = p[63:32]; lo = p[31:0];
        end else if (op == MD_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000; hi = 32'd0;
        end else if (op == MD_DIV) begin
            lo = 32'(sa / sb); hi = 32'(sa % sb);
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic alu_chk(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        AluControl_i = ctl; ScrA_i = a; ScrB_i = b;
        #1;
        e = alu_ref(ctl, a, b);
        chk($sformatf("alu_%b", ctl), {32'd0, AluResult_o}, {32'd0, e});
        chk("zero", {63'd0, Zero_o}, {63'd0, (e == 32'd0)});
    endtask

    // Issue one job and watch it for 40 cycles; optionally try a second issue mid-job.
    task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [31:0] eh, el;
        int done_at, n_done, n_busy, n_unstable;
        done_at = 0; n_done = 0; n_busy = 0; n_unstable = 0;
        md_ref(op, a, b, eh, el);
        @(negedge Clk_i);
        MdOp_i = op; ScrA_i = a; ScrB_i = b; MdStart_i = 1'b1;
        @(posedge Clk_i);
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk_i);
            MdStart_i = 1'b0;
            if (inject && k == 5) begin
                MdStart_i = 1'b1; MdOp_i = MD_DIV; ScrA_i = 32'd100; ScrB_i = 32'd7;
            end
            if (k == 10) alu_chk(4'b0010, $urandom, $urandom);
            if (Busy_o) begin
                n_busy++;
                if (Hi_o !== m_hi || Lo_o !== m_lo) n_unstable++;
            end
            if (Done_o) begin
                n_done++;
                if (done_at == 0) done_at = k;
            end
            @(posedge Clk_i);
        end
        m_hi = eh; m_lo = el;
        chk($sformatf("hi_op%0d", op), {32'd0, Hi_o}, {32'd0, eh});
        chk($sformatf("lo_op%0d", op), {32'd0, Lo_o}, {32'd0, el});
        chk("done_edge", 64'(done_at), 64'd34);
        chk("done_count", 64'(n_done), 64'd1);
        chk("busy_cycles", 64'(n_busy), 64'd33);
        chk("hilo_stable", 64'(n_unstable), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        int n_done;
        repeat (2) @(posedge Clk_i);
        #1;
        chk("rst_hi", {32'd0, Hi_o}, 64'd0);
        chk("rst_lo", {32'd0, Lo_o}, 64'd0);
        chk("rst_busy", {63'd0, Busy_o}, 64'd0);
        chk("rst_done", {63'd0, Done_o}, 64'd0);
        @(negedge Clk_i);
        RstN_i = 1'b1;

        alu_chk(4'b0111, 32'hFFFF_FFFF, 32'd1);
        alu_chk(4'b1000, 32'hFFFF_FFFF, 32'd1);
        alu_chk(4'b0110, 32'd5, 32'd5);
        alu_chk(4'b1011, 32'd31, 32'h8000_0000);
        alu_chk(4'b1100, 32'd0, 32'hABCD_1234);
        for (int i = 0; i < 160; i++) alu_chk(4'(i % 16), $urandom, $urandom);

        md_run(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        md_run(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        md_run(MD_DIVU, 32'd7, 32'd0, 1'b0);
        md_run(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
        md_run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md_run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
                default: b = $urandom;
            endcase
            md_run(3'(1 + (i % 4)), a, b, 1'b0);
        end

        // MTHI / MTLO: single-cycle writes with no completion pulse.
        @(negedge Clk_i);
        MdOp_i = MD_MTHI; ScrA_i = 32'h1234_5678; MdStart_i = 1'b1;
        @(negedge Clk_i);
        MdOp_i = MD_MTLO; ScrA_i = 32'h0BAD_F00D;
        chk("mthi", {32'd0, Hi_o}, 64'h1234_5678);
        chk("mthi_done", {63'd0, Done_o}, 64'd0);
        @(negedge Clk_i);
        MdStart_i = 1'b0;
        chk("mtlo", {32'd0, Lo_o}, 64'h0BAD_F00D);
        chk("mtlo_hi_kept", {32'd0, Hi_o}, 64'h1234_5678);
        chk("mt_busy", {63'd0, Busy_o}, 64'd0);
        n_done = 0;
        repeat (3) begin
            @(negedge Clk_i);
            if (Done_o) n_done++;
        end
        chk("mt_no_done", 64'(n_done), 64'd0);

        // Reset in RUN cycle 10 aborts the job.
        MdOp_i = MD_MULT; ScrA_i = 32'd1234; ScrB_i = 32'd5678; MdStart_i = 1'b1;
        @(posedge Clk_i);
        @(negedge Clk_i);
        MdStart_i = 1'b0;
        repeat (9) @(negedge Clk_i);
        chk("busy_before_rst", {63'd0, Busy_o}, 64'd1);
        RstN_i = 1'b0;
        @(negedge Clk_i);
        RstN_i = 1'b1;
        chk("abort_hi", {32'd0, Hi_o}, 64'd0);
        chk("abort_lo", {32'd0, Lo_o}, 64'd0);
        chk("abort_busy", {63'd0, Busy_o}, 64'd0);
        n_done = 0;
        repeat (45) begin
            @(negedge Clk_i);
            if (Done_o) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;

`ifdef ALU_MD_OVF_EN
        alu_chk(4'b0010, 32'h7FFF_FFFF, 32'd1);
        chk("ovf_add", {63'd0, Overflow_o}, 64'd1);
        alu_chk(4'b0110, 32'h8000_0000, 32'd1);
        chk("ovf_sub", {63'd0, Overflow_o}, 64'd1);
        alu_chk(4'b0010, 32'd1, 32'd1);
        chk("ovf_none", {63'd0, Overflow_o}, 64'd0);
        alu_chk(4'b0011, 32'h7FFF_FFFF, 32'd1);
        chk("ovf_xor", {63'd0, Overflow_o}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
